// File: rtl/rpn_pkg.sv
// Shared constants, opcodes and sequencer states for the RPN stack controller.
package rpn_pkg;

  localparam int DW = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_DROP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    PUSHN,
    POP1,
    REPL,
    PUSH2
  } state_t;

  // Two-operand opcodes that produce a reported result.
  function automatic logic is_binary(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator evaluation, result = f(B, A).
// Define RPN_SAT_EN to make ADD saturate at 255 and SUB floor at 0.
module rpn_alu
  import rpn_pkg::*;
(
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] a,
  output logic [DW-1:0] result
);

`ifdef RPN_SAT_EN
  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, b} + {1'b0, a};
  assign diff = {1'b0, b} - {1'b0, a};
`endif

  always_comb begin
    result = '0;
    case (opcode)
`ifdef RPN_SAT_EN
      OP_ADD: result = sum[DW]  ? '1 : sum[DW-1:0];
      OP_SUB: result = diff[DW] ? '0 : diff[DW-1:0];
`else
      OP_ADD: result = b + a;
      OP_SUB: result = b - a;
`endif
      OP_AND: result = b & a;
      OP_OR:  result = b | a;
      OP_XOR: result = b ^ a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN token sequencer driving an external LIFO stack through push/pop/wr_data.
// Optional RPN_SAT_EN selects saturating ADD/SUB inside rpn_alu.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic          tok_is_op,
  input  logic [DW-1:0] tok_data,
  output logic          push,
  output logic          pop,
  output logic [DW-1:0] wr_data,
  input  logic [DW-1:0] rd_data,
  output logic [CW-1:0] depth,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          err,
  input  logic          clr_err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  state_t        state_reg, state_next;
  logic [2:0]    op_reg, op_next;
  logic [DW-1:0] val_reg, val_next;
  logic [DW-1:0] a_reg, a_next;
  logic [DW-1:0] b_reg, b_next;
  logic [CW-1:0] depth_reg, depth_next;
  logic          err_reg, err_next;
  logic          err_set;
  logic [2:0]    tok_op;
  logic [DW-1:0] alu_result;

  assign tok_op    = tok_data[2:0];
  assign tok_ready = (state_reg == IDLE);
  assign depth     = depth_reg;
  assign err       = err_reg;

  // In REPL rd_data already shows B because A was popped the cycle before.
  rpn_alu u_alu (
    .opcode (op_reg),
    .b      (rd_data),
    .a      (a_reg),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      val_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      val_reg   <= val_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    val_next   = val_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    depth_next = depth_reg;
    err_set    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    wr_data    = '0;
    res_valid  = 1'b0;
    res_data   = '0;

    case (state_reg)
      IDLE: begin
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (depth_reg != FULL) begin
              val_next   = tok_data;
              state_next = PUSHN;
            end else begin
              err_set = 1'b1;
            end
          end else begin
            op_next = tok_op;
            case (tok_op)
              OP_DUP: begin
                if (depth_reg != '0 && depth_reg != FULL) begin
                  val_next   = rd_data;
                  state_next = PUSHN;
                end else begin
                  err_set = 1'b1;
                end
              end
              OP_DROP: begin
                if (depth_reg >= ONE) state_next = POP1;
                else                  err_set    = 1'b1;
              end
              default: begin
                if (depth_reg >= TWO) state_next = POP1;
                else                  err_set    = 1'b1;
              end
            endcase
          end
        end
      end

      PUSHN: begin
        push       = 1'b1;
        wr_data    = val_reg;
        depth_next = depth_reg + ONE;
        state_next = IDLE;
      end

      POP1: begin
        pop        = 1'b1;
        a_next     = rd_data;
        depth_next = depth_reg - ONE;
        state_next = (op_reg == OP_DROP) ? IDLE : REPL;
      end

      // push+pop together overwrite B in place.
      REPL: begin
        push   = 1'b1;
        pop    = 1'b1;
        b_next = rd_data;
        if (op_reg == OP_SWAP) begin
          wr_data    = a_reg;
          state_next = PUSH2;
        end else begin
          wr_data    = alu_result;
          res_valid  = is_binary(op_reg);
          res_data   = alu_result;
          state_next = IDLE;
        end
      end

      PUSH2: begin
        push       = 1'b1;
        wr_data    = b_reg;
        depth_next = depth_reg + ONE;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    err_next = err_set | (err_reg & ~clr_err);
  end

endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Reverse-Polish token sequencer that sits directly upstream of the 8-bit LIFO stack.
- Accepts number/operator tokens over a valid/ready handshake and drives the stack's push, pop and wr_data inputs.
- Reads the stack's rd_data (current top of stack) to evaluate operators, then writes results back.
- Maintains its own depth count, guards against overflow and underflow, and reports each computed result.

Parameters:
- DEPTH, 16: stack capacity in entries; must equal the attached stack's depth.
- CW, $clog2(DEPTH+1): width of the depth counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  block can accept a token; high only in IDLE.
- tok_is_op  in  1  1 = operator token, 0 = number token.
- tok_data  in  8  number value, or opcode in bits [2:0].
- push  out  1  stack push strobe.
- pop  out  1  stack pop strobe; push and pop together replace the top entry.
- wr_data  out  8  data to the stack.
- rd_data  in  8  current stack top; reflects a push/pop one cycle after the strobe.
- depth  out  CW  entries currently on the stack.
- res_valid  out  1  one-cycle pulse when an operator result is written.
- res_data  out  8  result value; valid with res_valid.
- err  out  1  sticky error flag.
- clr_err  in  1  synchronous clear of err.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, push=pop=0, wr_data=0, depth=0, res_valid=0, res_data=0, err=0, operand registers A and B =0. Reset mid-sequence abandons the operation immediately; no further strobes are issued.
- Opcodes: 0 ADD (B+A), 1 SUB (B-A), 2 AND, 3 OR, 4 XOR, 5 DUP, 6 SWAP, 7 DROP. A is the top entry, B the entry below it. Arithmetic is 8-bit and wraps modulo 256.
- Token acceptance: on a rising edge with tok_valid && tok_ready.
- States and outputs (Moore; push/pop/wr_data decoded from the registered state):
  - IDLE: no strobes. On acceptance, the legality check is made against depth:
    - number, depth<DEPTH: latch value, go to PUSHN.
    - DUP, 0<depth<DEPTH: latch rd_data, go to PUSHN.
    - DROP, depth>=1: go to POP1.
    - binary ops or SWAP, depth>=2: go to POP1.
    - otherwise: token consumed, set err, stay IDLE.
  - PUSHN: push=1, wr_data=latched value, depth+1, then IDLE.
  - POP1: pop=1, A<=rd_data, depth-1. DROP returns to IDLE; all other ops go to REPL.
  - REPL: push=1, pop=1, B<=rd_data. Binary ops: wr_data=f(rd_data,A) and res_valid=1 with res_data=wr_data, then IDLE. SWAP: wr_data=A, then PUSH2.
  - PUSH2: push=1, wr_data=B, depth+1, then IDLE.
- Latency: number/DUP/DROP tokens take 2 cycles from acceptance to the next tok_ready; binary ops take 3; SWAP takes 4.
- depth never exceeds DEPTH and never goes below 0; illegal tokens leave depth unchanged.
- err: set on an illegal token, cleared by clr_err. If set and clear occur in the same cycle, set wins.
- tok_data and tok_is_op are ignored when tok_valid is low or the block is not in IDLE.

Optional Feature:
- RPN_SAT_EN defined: ADD saturates at 255 and SUB floors at 0.
- RPN_SAT_EN undefined: ADD and SUB wrap modulo 256. All other opcodes are unaffected either way.

Decomposition:
- Package rpn_pkg holds:
  - opcode localparams OP_ADD through OP_DROP;
  - the state enum: IDLE, PUSHN, POP1, REPL, PUSH2;
  - the 8-bit data width constant.
- One sub-module, rpn_alu: purely combinational; inputs opcode, B and A; output result. It contains the RPN_SAT_EN logic.

Test Plan:
- Reset, then push 5 and 3, then ADD: stack push/pop sequence is correct, res_valid pulses once with res_data=8, depth=1, top=8.
- Push 3 then 5, then SUB: res_data=254 (wrap). With RPN_SAT_EN defined, res_data=0.
- Push 0x0F and 0xF0, SWAP then DROP: top=0xF0, depth=1. SWAP takes 4 cycles from acceptance to tok_ready.
- With depth=1, issue ADD: err=1, no push/pop, depth stays 1. Assert clr_err: err=0 next cycle.
- Push 16 numbers, then 17th number and DUP: both set err, depth=16, full stays asserted on the stack. Drop all 16, then DROP again: err, depth=0.
- Assert rst_n low during REPL of an ADD: all outputs return to reset values asynchronously and tok_ready=1 after release.
